spi_flash: RTL and testbench
============================

// Module: spi_flash
// PURPOSE
//   Single-byte SPI NOR-flash read master. On a one-cycle mem_valid request it issues
//   READ (0x03) + 24-bit address in SPI mode 0, shifts in one data byte, then returns
//   it on mem_data with a one-cycle mem_ready pulse. Sits between a CPU/boot memory
//   port and an external serial flash.
// PARAMETERS
//   CLK_DIV  1     sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
//   READ_CMD 8'h03 command opcode sent first
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   rstn       in   1   reset, synchronous, active-low
//   mem_valid  in   1   read request; sampled only in IDLE; may be a 1-cycle pulse
//   mem_addr   in   24  byte address; latched in the cycle mem_valid is accepted
//   mem_data   out  8   read byte; valid when mem_ready=1, held until next completion
//   mem_ready  out  1   1-cycle completion strobe
//   sclk       out  1   SPI clock, idles low (CPOL=0)
//   mosi       out  1   SPI data out, MSB first
//   miso       in   1   SPI data in
//   cs         out  1   chip select, active-low
// BEHAVIOUR
//   Reset (rstn=0 at posedge): state=IDLE, cs=1, sclk=0, mosi=0, mem_ready=0,
//     mem_data=8'h00, counters cleared. Reset mid-transfer aborts immediately
//     (cs high next edge); no mem_ready is produced.
//   Internal names (bench probes them): register `state`; localparams IDLE, SEND_CMD,
//     SEND_ADDR, READ_DATA, DONE; 3-bit `bit_counter` = index of current bit
//     within the byte being transferred, 0 = MSB.
//   IDLE: cs=1, sclk=0. mem_valid=1 at edge T -> latch {READ_CMD, mem_addr} into a
//     32-bit shift register, go SEND_CMD; at T+1 cs=0, sclk=0, mosi=bit 31.
//   Bit timing (mode 0): each bit = low phase (CLK_DIV cycles) then high phase
//     (CLK_DIV cycles). mosi changes only while sclk low (at falling edge / start);
//     miso sampled into a shift register at the clk edge that raises sclk.
//   SEND_CMD: 8 bits of opcode MSB first -> SEND_ADDR: 24 address bits, addr[23]
//     first -> READ_DATA: 8 bits; mosi=0; bit_counter 0..7; received MSB first.
//   After the high phase of the 40th bit: sclk=0, cs=1, state DONE for exactly one
//     cycle with mem_ready=1 and mem_data=received byte, then IDLE.
//   Latency: mem_ready asserted at T+1+80*CLK_DIV (T = accept edge); with CLK_DIV=1
//     that is 81 cycles. Exactly 40 sclk rising edges per transaction.
//   mem_valid while not IDLE is ignored (not queued). mem_valid in the DONE cycle is
//     ignored; a request held high is accepted in the following IDLE cycle.
//   mem_addr changes after acceptance do not affect the transfer in progress.
//   cs never toggles mid-transaction; sclk is never high while cs=1.
// TESTING
//   Reset: hold rstn=0 10 cycles -> cs=1, sclk=0, mosi=0, mem_ready=0, mem_data=0.
//   Read 0x0000AA, flash model returns byte 0xAA MSB-first on miso -> mosi stream
//     0x03,0x00,0x00,0xAA; 40 sclk rises; mem_ready 1 cycle at T+81; mem_data=0xAA.
//   Addr 0xFFFFFF, miso data 0x5A -> mosi address bits all 1; mem_data=0x5A; cs
//     high after completion.
//   mem_valid pulsed again mid-transfer (addr 0x123456) -> ignored; single
//     mem_ready; mosi address matches first request.
//   rstn=0 during SEND_ADDR -> cs=1, sclk=0 next edge, no mem_ready; new request
//     after reset completes normally.
//   Back-to-back: mem_valid held high -> second transfer starts the cycle after
//     DONE; each returns the correct byte.

Source files
------------

// File: rtl/spi_flash.sv
// Single-byte SPI NOR-flash read master (mode 0).
// Sends READ_CMD plus a 24-bit address MSB first, shifts in one byte and
// returns it on mem_data together with a one-cycle mem_ready strobe.
module spi_flash #(
    parameter int         CLK_DIV  = 1,
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid,
    input  logic [23:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_ready,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_ADDR = 3'd2,
        READ_DATA = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int             DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    state_t           state, state_d;
    logic [2:0]       bit_counter, bit_counter_d;
    logic [1:0]       addr_byte_q, addr_byte_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [7:0]       rx_q, rx_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             mem_ready_q, mem_ready_d;
    logic [7:0]       mem_data_q, mem_data_d;

    // Next-state logic: sclk toggles every CLK_DIV cycles; mosi only moves on
    // the falling half, miso is captured on the rising half.
    always_comb begin
        state_d       = state;
        bit_counter_d = bit_counter;
        addr_byte_d   = addr_byte_q;
        div_cnt_d     = div_cnt_q;
        shreg_d       = shreg_q;
        rx_d          = rx_q;
        cs_d          = cs_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        mem_ready_d   = 1'b0;
        mem_data_d    = mem_data_q;

        case (state)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (mem_valid) begin
                    shreg_d       = {READ_CMD, mem_addr};
                    state_d       = SEND_CMD;
                    cs_d          = 1'b0;
                    mosi_d        = READ_CMD[7];
                    bit_counter_d = 3'd0;
                    addr_byte_d   = 2'd0;
                    div_cnt_d     = '0;
                end
            end
            SEND_CMD, SEND_ADDR, READ_DATA: begin
                if (div_cnt_q != DIV_MAX) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (state == READ_DATA)
                            rx_d = {rx_q[6:0], miso};
                    end else begin
                        // end of a bit: drop sclk and present the next one
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[30:0], 1'b0};
                        mosi_d  = (state == READ_DATA) ? 1'b0 : shreg_q[30];
                        if (bit_counter != 3'd7) begin
                            bit_counter_d = bit_counter + 3'd1;
                        end else begin
                            bit_counter_d = 3'd0;
                            case (state)
                                SEND_CMD: state_d = SEND_ADDR;
                                SEND_ADDR: begin
                                    if (addr_byte_q == 2'd2) begin
                                        state_d = READ_DATA;
                                        mosi_d  = 1'b0;
                                    end else begin
                                        addr_byte_d = addr_byte_q + 2'd1;
                                    end
                                end
                                default: begin
                                    state_d     = DONE;
                                    cs_d        = 1'b1;
                                    mem_ready_d = 1'b1;
                                    mem_data_d  = rx_q;
                                end
                            endcase
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            bit_counter <= 3'd0;
            addr_byte_q <= 2'd0;
            div_cnt_q   <= '0;
            shreg_q     <= 32'h0;
            rx_q        <= 8'h00;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_data_q  <= 8'h00;
        end else begin
            state       <= state_d;
            bit_counter <= bit_counter_d;
            addr_byte_q <= addr_byte_d;
            div_cnt_q   <= div_cnt_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            mem_ready_q <= mem_ready_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign mem_ready = mem_ready_q;
    assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_spi_flash.sv
// Scoreboard bench for spi_flash: requests push {addr, flash byte}; a monitor
// acts as the flash on miso and checks each completion against the queue head.
module tb_spi_flash;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [23:0] mem_addr = 24'h0;
    logic        miso = 1'b0;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        sclk;
    logic        mosi;
    logic        cs;

    spi_flash #(.CLK_DIV(1), .READ_CMD(8'h03)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs        (cs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor / flash model state
    int          cyc = 0;
    int          rises = 0;
    int          glitch = 0;
    int          done_cnt = 0;
    int          start_cyc = 0;
    int          last_done_cyc = 0;
    int          gap = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [39:0] mosi_sr = 40'h0;

    // Samples outputs on the falling clk edge; drives miso after sclk falls.
    always @(negedge clk) begin
        txn_t t;
        cyc++;
        if (!rstn) begin
            rises  = 0;
            glitch = 0;
            miso   = 1'b0;
        end else begin
            if (prev_cs && !cs) begin
                rises     = 0;
                start_cyc = cyc;
                gap       = cyc - last_done_cyc;
                mosi_sr   = 40'h0;
            end
            if (!prev_sclk && sclk) begin
                rises++;
                mosi_sr = {mosi_sr[38:0], mosi};
            end
            if (prev_sclk && !sclk && rises >= 32 && rises < 40 && exp_q.size() > 0)
                miso = exp_q[0].data[7 - (rises - 32)];
            if (sclk && cs) glitch++;
            if (!prev_cs && cs && !mem_ready) glitch++;
            if (mem_ready) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 40'd1, 40'd0);
                end else begin
                    t = exp_q.pop_front();
                    chk("latency", 40'(cyc - start_cyc), 40'd80);
                    chk("sclk_rises", 40'(rises), 40'd40);
                    chk("mosi_stream", mosi_sr, {8'h03, t.addr, 8'h00});
                    chk("mem_data", 40'(mem_data), 40'(t.data));
                    chk("cs_sclk_integrity", 40'(glitch), 40'd0);
                end
            end
        end
        prev_sclk = sclk;
        prev_cs   = cs;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [23:0] addr, input logic [7:0] data);
        txn_t t;
        tick();
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
        mem_addr  = addr;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        mem_addr  = ~addr;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 400) begin
            tick();
            k++;
        end
        chk("done_count", 40'(done_cnt), 40'(n));
    endtask

    initial begin
        txn_t t;
        rstn = 1'b0;
        repeat (10) tick();
        chk("rst_cs", 40'(cs), 40'd1);
        chk("rst_sclk", 40'(sclk), 40'd0);
        chk("rst_mosi", 40'(mosi), 40'd0);
        chk("rst_ready", 40'(mem_ready), 40'd0);
        chk("rst_data", 40'(mem_data), 40'd0);
        rstn = 1'b1;

        issue(24'h0000AA, 8'hAA);
        wait_done(1);

        issue(24'hFFFFFF, 8'h5A);
        wait_done(2);
        tick();
        chk("cs_idle_after", 40'(cs), 40'd1);
        chk("sclk_idle_after", 40'(sclk), 40'd0);

        // second request mid-transfer must be dropped
        issue(24'h000100, 8'h3C);
        repeat (20) tick();
        mem_addr  = 24'h123456;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        wait_done(3);
        repeat (100) tick();
        chk("single_ready", 40'(done_cnt), 40'd3);

        // reset while in SEND_ADDR
        issue(24'h000200, 8'hC3);
        repeat (25) tick();
        rstn = 1'b0;
        tick();
        chk("abort_cs", 40'(cs), 40'd1);
        chk("abort_sclk", 40'(sclk), 40'd0);
        chk("abort_ready", 40'(mem_ready), 40'd0);
        repeat (3) tick();
        t = exp_q.pop_back();
        rstn = 1'b1;
        repeat (100) tick();
        chk("no_ready_after_abort", 40'(done_cnt), 40'd3);

        issue(24'hABCDEF, 8'h96);
        wait_done(4);

        // back-to-back with mem_valid held high
        tick();
        t.addr = 24'h000010; t.data = 8'h11; exp_q.push_back(t);
        t.addr = 24'h000020; t.data = 8'hE7; exp_q.push_back(t);
        mem_addr  = 24'h000010;
        mem_valid = 1'b1;
        wait_done(5);
        mem_addr = 24'h000020;
        repeat (2) tick();
        mem_valid = 1'b0;
        wait_done(6);
        chk("b2b_gap", 40'(gap), 40'd2);
        chk("queue_empty", 40'(exp_q.size()), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
